// File: rtl/sound_ch3_wave_sequencer.sv
// Wave channel playback controller: frequency timer, 32-step sample pointer,
// length counter and shared wave RAM fetch with CPU priority.
module sound_ch3_wave_sequencer #(
    parameter int FREQ_W = 11,
    parameter int LEN_W  = 9
) (
    input  logic              I_CLK,
    input  logic              I_RESET_L,
    input  logic              I_TICK_WAVE,
    input  logic              I_TICK_LEN,
    input  logic              I_DAC_EN,
    input  logic [FREQ_W-1:0] I_FREQ,
    input  logic              I_LEN_LOAD,
    input  logic [7:0]        I_LEN_VAL,
    input  logic              I_LEN_EN,
    input  logic              I_TRIGGER,
    input  logic              I_CPU_WAVE_ACC,
    output logic              O_RAM_RD_REQ,
    output logic [3:0]        O_RAM_RD_ADDR,
    input  logic [7:0]        I_RAM_RD_DATA,
    output logic [3:0]        O_SAMPLE,
    output logic              O_SAMPLE_VALID,
    output logic [4:0]        O_PTR,
    output logic              O_CH_ON
);

    localparam int TMR_W = FREQ_W + 1;
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(256);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, RUN} state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [4:0]       ptr;
    logic [LEN_W-1:0] len_cnt;
    logic [3:0]       sample_q;
    logic [3:0]       addr_q;
    logic             ch_on;

    logic             grant;
    logic             expire;
    logic             len_tick;
    logic             len_expire;
    logic [LEN_W-1:0] len_next;
    logic [TMR_W-1:0] reload;
    logic [4:0]       ptr_inc;
    logic [3:0]       nibble;

    always_comb begin
        reload     = TMR_W'(1 << FREQ_W) - TMR_W'(I_FREQ);
        grant      = O_RAM_RD_REQ & ~I_CPU_WAVE_ACC;
        expire     = I_TICK_WAVE & (timer == TMR_W'(1));
        ptr_inc    = ptr + 5'd1;
        // A length load in the same cycle swallows the length tick.
        len_tick   = I_TICK_LEN & I_LEN_EN & (len_cnt != '0) & ~I_LEN_LOAD;
        len_expire = len_tick & (len_cnt == LEN_W'(1));
        if (I_LEN_LOAD)
            len_next = LEN_FULL - LEN_W'(I_LEN_VAL);
        else if (len_tick)
            len_next = len_cnt - LEN_W'(1);
        else
            len_next = len_cnt;
        nibble     = ptr[0] ? I_RAM_RD_DATA[3:0] : I_RAM_RD_DATA[7:4];
    end

    // RAM data arrives the cycle after the grant, so the WAIT-cycle sample is
    // taken straight from the read port and held in sample_q afterwards.
    assign O_RAM_RD_REQ   = (state == FETCH);
    assign O_RAM_RD_ADDR  = addr_q;
    assign O_SAMPLE_VALID = (state == WAIT);
    assign O_SAMPLE       = (state == WAIT) ? nibble : sample_q;
    assign O_PTR          = ptr;
    assign O_CH_ON        = ch_on;

    always_ff @(posedge I_CLK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            state    <= IDLE;
            timer    <= '0;
            ptr      <= '0;
            len_cnt  <= '0;
            sample_q <= '0;
            addr_q   <= '0;
            ch_on    <= 1'b0;
        end else begin
            len_cnt <= len_next;
            if (!I_DAC_EN) begin
                state    <= IDLE;
                ch_on    <= 1'b0;
                sample_q <= '0;
            end else if (I_TRIGGER) begin
                state  <= FETCH;
                ch_on  <= 1'b1;
                ptr    <= '0;
                addr_q <= '0;
                timer  <= reload;
                if (len_next == '0)
                    len_cnt <= LEN_FULL;
            end else if (len_expire) begin
                state    <= IDLE;
                ch_on    <= 1'b0;
                sample_q <= '0;
            end else if (state != IDLE) begin
                if (state == WAIT)
                    sample_q <= nibble;
                if (I_TICK_WAVE) begin
                    if (expire) begin
                        timer  <= reload;
                        ptr    <= ptr_inc;
                        addr_q <= ptr_inc[4:1];
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                // Expiry always restarts the fetch, dropping any grant in flight.
                if (expire) begin
                    state <= FETCH;
                end else begin
                    case (state)
                        FETCH:   if (grant) state <= WAIT;
                        WAIT:    state <= RUN;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sound_ch3_wave_sequencer.sv
// Bench for sound_ch3_wave_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a flag-based reference model.
module tb_sound_ch3_wave_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tick_wave;
    logic        tick_len;
    logic        dac_en;
    logic [10:0] freq;
    logic        len_load;
    logic [7:0]  len_val;
    logic        len_en;
    logic        trig;
    logic        cpu;
    logic        req;
    logic [3:0]  addr;
    logic [7:0]  rd_data;
    logic [3:0]  sample;
    logic        valid;
    logic [4:0]  ptr;
    logic        on;

    sound_ch3_wave_sequencer #(.FREQ_W(11), .LEN_W(9)) dut (
        .I_CLK          (clk),
        .I_RESET_L      (rst_n),
        .I_TICK_WAVE    (tick_wave),
        .I_TICK_LEN     (tick_len),
        .I_DAC_EN       (dac_en),
        .I_FREQ         (freq),
        .I_LEN_LOAD     (len_load),
        .I_LEN_VAL      (len_val),
        .I_LEN_EN       (len_en),
        .I_TRIGGER      (trig),
        .I_CPU_WAVE_ACC (cpu),
        .O_RAM_RD_REQ   (req),
        .O_RAM_RD_ADDR  (addr),
        .I_RAM_RD_DATA  (rd_data),
        .O_SAMPLE       (sample),
        .O_SAMPLE_VALID (valid),
        .O_PTR          (ptr),
        .O_CH_ON        (on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous wave RAM: data for the presented address appears next cycle.
    logic [7:0] ram [16];
    always @(posedge clk) rd_data <= ram[addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: channel on/off plus "fetch outstanding" and
    // "data arriving now" flags, advanced once per clock edge.
    bit m_on, m_fetch, m_due;
    int m_ptr, m_timer, m_len, m_held;

    function automatic int nib(input int p);
        logic [7:0] b;
        b = ram[p / 2];
        return (p % 2 == 1) ? int'(b[3:0]) : int'(b[7:4]);
    endfunction

    task automatic model_reset();
        m_on = 0; m_fetch = 0; m_due = 0;
        m_ptr = 0; m_timer = 0; m_len = 0; m_held = 0;
    endtask

    task automatic model_edge();
        bit expired;
        expired = 0;
        if (len_load) begin
            m_len = 256 - int'(len_val);
        end else if (tick_len && len_en && m_len > 0) begin
            m_len--;
            expired = (m_len == 0);
        end
        if (!dac_en) begin
            m_on = 0; m_fetch = 0; m_due = 0; m_held = 0;
        end else if (trig) begin
            if (m_len == 0) m_len = 256;
            m_on = 1; m_fetch = 1; m_due = 0;
            m_ptr = 0;
            m_timer = 2048 - int'(freq);
        end else if (expired) begin
            m_on = 0; m_fetch = 0; m_due = 0; m_held = 0;
        end else if (m_on) begin
            if (m_due) begin
                m_held = nib(m_ptr);
                m_due = 0;
            end else if (m_fetch && !cpu) begin
                m_fetch = 0;
                m_due = 1;
            end
            if (tick_wave) begin
                if (m_timer == 1) begin
                    m_timer = 2048 - int'(freq);
                    m_ptr = (m_ptr + 1) % 32;
                    m_fetch = 1;
                    m_due = 0;
                end else begin
                    m_timer--;
                end
            end
        end
    endtask

    function automatic logic [15:0] model_vec();
        int s;
        s = m_due ? nib(m_ptr) : m_held;
        return {m_on && m_fetch, 4'(m_ptr / 2), m_due, 4'(s), 5'(m_ptr), m_on};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {req, addr, valid, sample, ptr, on};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_pulses();
        trig = 0; tick_wave = 0; tick_len = 0; len_load = 0; cpu = 0;
    endtask

    typedef struct {
        logic       trig;
        logic       cpu;
        logic       tick;
        logic       req;
        logic       valid;
        logic [3:0] sample;
        logic [4:0] ptr;
        logic       on;
    } vec_t;

    vec_t vec [14];

    task automatic setv(input int unsigned i, input logic [2:0] in, input logic [11:0] out);
        {vec[i].trig, vec[i].cpu, vec[i].tick} = in;
        {vec[i].req, vec[i].valid, vec[i].sample, vec[i].ptr, vec[i].on} = out;
    endtask

    initial begin
        int unsigned nvalid, nodd;
        logic [3:0] s0, s1;

        // inputs {trig,cpu,tick}; outputs {req,valid,sample,ptr,on}
        setv(0,  3'b110, {1'b1, 1'b0, 4'h0, 5'd0, 1'b1});
        for (int unsigned i = 1; i <= 5; i++)
            setv(i, 3'b010, {1'b1, 1'b0, 4'h0, 5'd0, 1'b1});
        setv(6,  3'b000, {1'b0, 1'b1, 4'hA, 5'd0, 1'b1});
        setv(7,  3'b000, {1'b0, 1'b0, 4'hA, 5'd0, 1'b1});
        setv(8,  3'b001, {1'b0, 1'b0, 4'hA, 5'd0, 1'b1});
        setv(9,  3'b001, {1'b1, 1'b0, 4'hA, 5'd1, 1'b1});
        setv(10, 3'b000, {1'b0, 1'b1, 4'h5, 5'd1, 1'b1});
        setv(11, 3'b000, {1'b0, 1'b0, 4'h5, 5'd1, 1'b1});
        setv(12, 3'b011, {1'b0, 1'b0, 4'h5, 5'd1, 1'b1});
        setv(13, 3'b011, {1'b1, 1'b0, 4'h5, 5'd2, 1'b1});

        for (int unsigned i = 0; i < 16; i++)
            ram[i] = 8'hA5 ^ 8'(i * 17);

        clear_pulses();
        dac_en = 1; freq = 11'd2046; len_val = 8'h00; len_en = 0;
        rst_n = 0;
        model_reset();
        #1;
        check("reset_state", dut_vec(), 16'h0000);
        @(negedge clk);
        rst_n = 1;

        // Directed table: CPU contention on the first fetch, then a second step.
        for (int unsigned i = 0; i < 14; i++) begin
            trig = vec[i].trig; cpu = vec[i].cpu; tick_wave = vec[i].tick;
            step();
            check($sformatf("vec%0d", i), {req, valid, sample, ptr, on},
                  {vec[i].req, vec[i].valid, vec[i].sample, vec[i].ptr, vec[i].on});
        end

        // Asynchronous reset while a contended request is pending.
        #2 rst_n = 0;
        #1 check("async_reset_mid_fetch", dut_vec(), 16'h0000);
        clear_pulses();
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // Pointer cadence and wrap with a 2-tick period.
        freq = 11'd2046; trig = 1;
        step();
        trig = 0; tick_wave = 1;
        nvalid = 0; nodd = 0; s0 = 4'h0; s1 = 4'h0;
        for (int unsigned k = 1; k <= 64; k++) begin
            step();
            if (valid) begin
                if (nvalid == 0) s0 = sample;
                if (nvalid == 1) s1 = sample;
                nvalid++;
                if (k % 2 == 1) nodd++;
            end
            if (k == 2)  check("ptr_after_2", 32'(ptr), 32'd1);
            if (k == 62) check("ptr_after_62", 32'(ptr), 32'd31);
            if (k == 64) check("ptr_wrap_64", 32'(ptr), 32'd0);
        end
        tick_wave = 0;
        check("valid_count", nvalid, 32);
        check("valid_every_2", nodd, 32);
        check("first_sample", 32'(s0), 32'hA);
        check("second_sample", 32'(s1), 32'h5);

        // Length expiry after two ticks, load and trigger together.
        dac_en = 0;
        step();
        dac_en = 1; len_en = 1; len_load = 1; len_val = 8'hFE; trig = 1;
        step();
        clear_pulses();
        repeat (3) step();
        check("len_play", {on, sample}, {1'b1, 4'hA});
        tick_len = 1;
        step();
        check("len_tick1_on", 32'(on), 32'd1);
        step();
        tick_len = 0;
        check("len_expired", {on, sample, req, valid}, 7'b0);
        trig = 1;
        step();
        trig = 0;
        check("retrig_on", {on, req}, 2'b11);
        tick_len = 1;
        repeat (255) step();
        check("len256_still_on", 32'(on), 32'd1);
        step();
        tick_len = 0;
        check("len256_expired", 32'(on), 32'd0);

        // Trigger ignored with the DAC off; DAC drop stops a playing channel.
        dac_en = 0; trig = 1;
        step();
        check("trig_dac_off", {on, req}, 2'b00);
        dac_en = 1;
        step();
        check("trig_dac_on", {on, req}, 2'b11);
        trig = 0; dac_en = 0;
        step();
        check("dac_drop", {on, req}, 2'b00);
        dac_en = 1;

        // Trigger coinciding with length expiry and timer expiry.
        freq = 11'd2047; len_load = 1; len_val = 8'hFF; trig = 1;
        step();
        clear_pulses();
        tick_wave = 1;
        repeat (3) step();
        check("coinc_pre_ptr", {on, ptr}, {1'b1, 5'd3});
        trig = 1; tick_len = 1;
        step();
        clear_pulses();
        check("coinc_restart", {on, ptr, req}, {1'b1, 5'd0, 1'b1});
        tick_len = 1;
        repeat (255) step();
        check("coinc_len256_on", 32'(on), 32'd1);
        step();
        tick_len = 0;
        check("coinc_len256_off", 32'(on), 32'd0);

        // Randomized traffic against the reference model.
        for (int unsigned i = 0; i < 16; i++)
            ram[i] = 8'($urandom_range(255));
        #2 rst_n = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1;
        dac_en = 1; len_en = 1; freq = 11'd2046;
        for (int unsigned c = 0; c < 4000; c++) begin
            if (dac_en) dac_en = ($urandom_range(99) != 0);
            else        dac_en = ($urandom_range(4) == 0);
            if ($urandom_range(49) == 0) len_en = ~len_en;
            if ($urandom_range(99) == 0) freq = 11'(2040 + $urandom_range(7));
            trig      = ($urandom_range(39) == 0);
            tick_wave = ($urandom_range(1) == 1);
            tick_len  = ($urandom_range(7) == 0);
            len_load  = ($urandom_range(59) == 0);
            len_val   = ($urandom_range(1) == 1) ? 8'(252 + $urandom_range(3))
                                                 : 8'($urandom_range(255));
            cpu       = ($urandom_range(3) == 0);
            step();
            check("random", dut_vec(), model_vec());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sound_ch3_wave_sequencer.md
Name: sound_ch3_wave_sequencer

Overview:
- Playback controller for sound channel 3 (the wave channel).
- Owns the frequency timer, the 32-step sample pointer, the length counter and the channel-on state.
- Fetches wave RAM bytes through a read port it shares with the CPU; the CPU always has priority.
- Delivers one 4-bit sample per step to the volume/DAC stage downstream.

Parameters:
FREQ_W, 11, width of the frequency field (NR33/NR34[2:0])
LEN_W, 9, width of the length counter (holds 0..256)

Ports:
I_CLK  in  1  system clock
I_RESET_L  in  1  reset, asynchronous assert, active-low
I_TICK_WAVE  in  1  one-cycle strobe at the wave timer rate (2 MHz equivalent)
I_TICK_LEN  in  1  one-cycle strobe at 256 Hz from the frame sequencer
I_DAC_EN  in  1  NR30[7]
I_FREQ  in  FREQ_W  frequency value {NR34[2:0],NR33}
I_LEN_LOAD  in  1  one-cycle pulse on an NR31 write
I_LEN_VAL  in  8  NR31 data
I_LEN_EN  in  1  NR34[6]
I_TRIGGER  in  1  one-cycle pulse on an NR34 write with bit7=1
I_CPU_WAVE_ACC  in  1  CPU is accessing FF30-FF3F this cycle
O_RAM_RD_REQ  out  1  wave RAM read request
O_RAM_RD_ADDR  out  4  wave RAM byte address
I_RAM_RD_DATA  in  8  wave RAM read data, valid the cycle after a grant
O_SAMPLE  out  4  current sample nibble
O_SAMPLE_VALID  out  1  one-cycle pulse when O_SAMPLE updates
O_PTR  out  5  current sample pointer
O_CH_ON  out  1  channel active (feeds NR52 bit2)

Behaviour:
- Reset (async, I_RESET_L=0):
  - state=IDLE; timer=0, ptr=0, len_cnt=0.
  - All outputs 0.
- States: IDLE, FETCH, WAIT, RUN.
- Grant: grant = O_RAM_RD_REQ & ~I_CPU_WAVE_ACC. O_RAM_RD_REQ=1 only in FETCH. O_RAM_RD_ADDR = ptr[4:1], registered.
- Trigger, when I_TRIGGER=1 and I_DAC_EN=1:
  - O_CH_ON=1, ptr=0, timer=2048-I_FREQ.
  - If len_cnt==0, len_cnt=256.
  - Next state FETCH.
  - Trigger while already playing restarts identically.
  - Trigger with I_DAC_EN=0: no state change.
- Frequency timer: runs in FETCH/WAIT/RUN only.
  - On I_TICK_WAVE: if timer==1, reload 2048-I_FREQ, ptr=ptr+1 (wraps 31->0), next state FETCH. Otherwise timer=timer-1.
  - An I_FREQ change takes effect at the next reload only.
  - Period in ticks = 2048-I_FREQ (range 1..2048, timer is 12 bits).
- FETCH: hold request.
  - On grant, go to WAIT.
  - If the CPU holds the port and the timer expires meanwhile, ptr advances and the address follows. The fetch for the skipped step is dropped.
- WAIT (exactly 1 cycle):
  - O_SAMPLE = ptr[0] ? data[3:0] : data[7:4].
  - O_SAMPLE_VALID=1 for that cycle; go to RUN.
  - If a timer expiry coincides with WAIT, the sample still completes, then state goes to FETCH for the new ptr.
- Latency: timer expiry -> O_SAMPLE_VALID in 2 cycles with no CPU contention; 2+N cycles with N contended cycles.
- Length counter:
  - I_LEN_LOAD: len_cnt = 256 - I_LEN_VAL, range 1..256.
  - On I_TICK_LEN with I_LEN_EN=1 and len_cnt>0: decrement. Reaching 0 forces O_CH_ON=0, state=IDLE, O_SAMPLE=0.
  - I_LEN_EN=0 freezes the counter.
- DAC off: I_DAC_EN=0 in any state forces O_CH_ON=0, IDLE, O_SAMPLE=0 on the next edge.
- Priority when events coincide in one cycle, highest first: reset > DAC off > trigger > length expiry > timer expiry.
  - I_LEN_LOAD beats I_TICK_LEN; the tick is lost.
  - Trigger and I_LEN_LOAD together: load first, then the trigger's "if 0 then 256" check uses the loaded value.
- In IDLE: O_SAMPLE=0, no RAM requests, timer frozen. O_PTR holds its last value.

Test Plan:
- Reset mid-FETCH with REQ high -> on I_RESET_L=0 all outputs 0 immediately, with no clock edge required.
- RAM byte 0=0xA5, I_FREQ=2046, trigger, I_TICK_WAVE every cycle -> samples 0xA then 0x5, with O_SAMPLE_VALID every 2 ticks. O_PTR goes 0,1,2 and wraps 31->0 after 64 ticks.
- I_CPU_WAVE_ACC held high for 5 cycles during FETCH -> REQ stays high, no VALID. Grant on cycle 6; VALID on cycle 7 with the correct nibble.
- I_LEN_VAL=0xFE, I_LEN_EN=1, trigger, then 2 I_TICK_LEN -> O_CH_ON falls on the edge after the 2nd tick and O_SAMPLE=0. Re-trigger -> len_cnt=256, O_CH_ON=1.
- I_TRIGGER with I_DAC_EN=0 -> O_CH_ON stays 0, no REQ. Dropping I_DAC_EN while playing -> O_CH_ON=0 the next cycle.
- I_TRIGGER coincident with a length-expiry tick and with a timer expiry -> channel restarts: ptr=0, O_CH_ON=1, len_cnt=256.
